// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared types and widths for the Ethernet TX arbiter
package eth_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_HEADER, ARB_PAYLOAD} arb_state_t;

  localparam int MAC_WIDTH      = 48;
  localparam int ETH_TYPE_WIDTH = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// rtl/eth_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module eth_rr_arbiter
  import eth_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant_oh,
  output logic [IDX_W-1:0]     grant_idx
);

  int j;

  // Scan from farthest to nearest so the last hit written is the closest to ptr.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    j         = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_PORTS;
      if (req[j]) begin
        grant_oh    = '0;
        grant_oh[j] = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - frame-atomic round-robin mux of header+payload sources onto one TX framer
// Optional per-source completed-frame counters: ETH_TX_ARBITER_STATS_EN
module eth_tx_arbiter
  import eth_arb_pkg::*;
#(
  parameter  int NUM_PORTS        = 2,
  parameter  int AXIS_TDATA_WIDTH = 8,
  localparam int IDX_W            = idx_width(NUM_PORTS),
  localparam int KEEP_W           = (AXIS_TDATA_WIDTH + 7) / 8
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic [NUM_PORTS-1:0]                           eth_header_in_valid,
  output logic [NUM_PORTS-1:0]                           eth_header_in_ready,
  input  logic [NUM_PORTS-1:0][MAC_WIDTH-1:0]            eth_header_in_dest_mac,
  input  logic [NUM_PORTS-1:0][MAC_WIDTH-1:0]            eth_header_in_src_mac,
  input  logic [NUM_PORTS-1:0][ETH_TYPE_WIDTH-1:0]       eth_header_in_eth_type,
  input  logic [NUM_PORTS-1:0][AXIS_TDATA_WIDTH-1:0]     eth_payload_in_tdata,
  input  logic [NUM_PORTS-1:0][KEEP_W-1:0]               eth_payload_in_tkeep,
  input  logic [NUM_PORTS-1:0]                           eth_payload_in_tvalid,
  output logic [NUM_PORTS-1:0]                           eth_payload_in_tready,
  input  logic [NUM_PORTS-1:0]                           eth_payload_in_tlast,
  input  logic [NUM_PORTS-1:0]                           eth_payload_in_tuser,
  output logic                                           eth_header_out_valid,
  input  logic                                           eth_header_out_ready,
  output logic [MAC_WIDTH-1:0]                           eth_header_out_dest_mac,
  output logic [MAC_WIDTH-1:0]                           eth_header_out_src_mac,
  output logic [ETH_TYPE_WIDTH-1:0]                      eth_header_out_eth_type,
  output logic [AXIS_TDATA_WIDTH-1:0]                    eth_payload_out_tdata,
  output logic [KEEP_W-1:0]                              eth_payload_out_tkeep,
  output logic                                           eth_payload_out_tvalid,
  input  logic                                           eth_payload_out_tready,
  output logic                                           eth_payload_out_tlast,
  output logic                                           eth_payload_out_tuser,
`ifdef ETH_TX_ARBITER_STATS_EN
  output logic [NUM_PORTS-1:0][31:0]                     frame_count,
`endif
  output logic [IDX_W-1:0]                               grant_idx,
  output logic                                           busy
);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 busy_q, busy_d;
  logic [NUM_PORTS-1:0] arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 hdr_fire;
  logic                 last_fire;

  eth_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req       (eth_header_in_valid),
    .ptr       (ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  // Data fields always follow grant_q; only the valids/readys are gated by state.
  assign eth_header_out_dest_mac = eth_header_in_dest_mac[grant_q];
  assign eth_header_out_src_mac  = eth_header_in_src_mac[grant_q];
  assign eth_header_out_eth_type = eth_header_in_eth_type[grant_q];
  assign eth_payload_out_tdata   = eth_payload_in_tdata[grant_q];
  assign eth_payload_out_tkeep   = eth_payload_in_tkeep[grant_q];
  assign eth_payload_out_tlast   = eth_payload_in_tlast[grant_q];
  assign eth_payload_out_tuser   = eth_payload_in_tuser[grant_q];
  assign eth_header_out_valid    = (state_q == ARB_HEADER)  && eth_header_in_valid[grant_q];
  assign eth_payload_out_tvalid  = (state_q == ARB_PAYLOAD) && eth_payload_in_tvalid[grant_q];

  assign hdr_fire  = eth_header_out_valid && eth_header_out_ready;
  assign last_fire = eth_payload_out_tvalid && eth_payload_out_tready && eth_payload_out_tlast;

  always_comb begin
    eth_header_in_ready   = '0;
    eth_payload_in_tready = '0;
    if (state_q == ARB_HEADER)  eth_header_in_ready[grant_q]   = eth_header_out_ready;
    if (state_q == ARB_PAYLOAD) eth_payload_in_tready[grant_q] = eth_payload_out_tready;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|arb_oh) begin
          grant_d = arb_idx;
          state_d = ARB_HEADER;
        end
      end
      ARB_HEADER: begin
        if (hdr_fire) begin
          state_d = ARB_PAYLOAD;
          ptr_d   = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      ARB_PAYLOAD: begin
        if (last_fire) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = busy_q;

`ifdef ETH_TX_ARBITER_STATS_EN
  logic [NUM_PORTS-1:0][31:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (last_fire) frame_count_d[grant_q] = frame_count_q[grant_q] + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_count_q <= '0;
    else          frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - directed self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        hv = '0, hr;
  logic [1:0][47:0]  hdest = '0, hsrc = '0;
  logic [1:0][15:0]  htype = '0;
  logic [1:0][7:0]   tdata = '0;
  logic [1:0][0:0]   tkeep = '1;
  logic [1:0]        tvalid = '0, tready, tlast = '0, tuser = '0;
  logic              ohv, ohr = 1'b1;
  logic [47:0]       odest, osrc;
  logic [15:0]       otype;
  logic [7:0]        otdata;
  logic [0:0]        otkeep;
  logic              otvalid, otready = 1'b1, otlast, otuser;
  logic [0:0]        grant_idx;
  logic              busy;
`ifdef ETH_TX_ARBITER_STATS_EN
  logic [1:0][31:0]  frame_count;
`endif

  int errors = 0, checks = 0, timeouts = 0, cyc = 0;
  int busy_bad = 0, ready_bad = 0;
  bit bp_en = 1'b0;
  int hdr_grant[$], hdr_type[$], hdr_cyc[$], beat_grant[$], beat_data[$], beat_last[$], beat_user[$], beat_cyc[$];
  logic [47:0] hdr_dest[$];

  eth_tx_arbiter #(.NUM_PORTS(2), .AXIS_TDATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .eth_header_in_valid(hv), .eth_header_in_ready(hr),
    .eth_header_in_dest_mac(hdest), .eth_header_in_src_mac(hsrc), .eth_header_in_eth_type(htype),
    .eth_payload_in_tdata(tdata), .eth_payload_in_tkeep(tkeep), .eth_payload_in_tvalid(tvalid),
    .eth_payload_in_tready(tready), .eth_payload_in_tlast(tlast), .eth_payload_in_tuser(tuser),
    .eth_header_out_valid(ohv), .eth_header_out_ready(ohr),
    .eth_header_out_dest_mac(odest), .eth_header_out_src_mac(osrc), .eth_header_out_eth_type(otype),
    .eth_payload_out_tdata(otdata), .eth_payload_out_tkeep(otkeep), .eth_payload_out_tvalid(otvalid),
    .eth_payload_out_tready(otready), .eth_payload_out_tlast(otlast), .eth_payload_out_tuser(otuser),
`ifdef ETH_TX_ARBITER_STATS_EN
    .frame_count(frame_count),
`endif
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    ohr     = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    otready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (ohv && ohr) begin
        hdr_grant.push_back(int'(grant_idx)); hdr_dest.push_back(odest);
        hdr_type.push_back(int'(otype)); hdr_cyc.push_back(cyc);
      end
      if (otvalid && otready) begin
        beat_grant.push_back(int'(grant_idx)); beat_data.push_back(int'(otdata));
        beat_last.push_back(int'(otlast)); beat_user.push_back(int'(otuser)); beat_cyc.push_back(cyc);
        if (!busy) busy_bad++;
      end
      for (int p = 0; p < 2; p++)
        if ((hr[p] || tready[p]) && !(busy && int'(grant_idx) == p)) ready_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic clear_capture();
    hdr_grant.delete(); hdr_dest.delete(); hdr_type.delete(); hdr_cyc.delete();
    beat_grant.delete(); beat_data.delete(); beat_last.delete(); beat_user.delete(); beat_cyc.delete();
    busy_bad = 0; ready_bad = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input int p, input int len, input logic [47:0] dest,
                             input logic [15:0] typ, input int base);
    int n;
    hdest[p] = dest; hsrc[p] = 48'h0200_0000_0000 | 48'(p); htype[p] = typ; hv[p] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!hr[p] && reset_n && n < 2000) begin @(negedge clk); n++; end
    if (!reset_n || n >= 2000) begin
      if (n >= 2000) timeouts++;
      hv[p] = 1'b0; return;
    end
    @(posedge clk); #1 hv[p] = 1'b0;
    for (int i = 0; i < len; i++) begin
      tvalid[p] = 1'b1; tdata[p] = 8'(base + i); tlast[p] = (i == len - 1); tuser[p] = tdata[p][0];
      n = 0;
      @(negedge clk);
      while (!tready[p] && reset_n && n < 2000) begin @(negedge clk); n++; end
      if (!reset_n || n >= 2000) begin
        if (n >= 2000) timeouts++;
        tvalid[p] = 1'b0; tlast[p] = 1'b0; return;
      end
      @(posedge clk); #1;
    end
    tvalid[p] = 1'b0; tlast[p] = 1'b0;
  endtask

  task automatic test_reset();
    hv = 2'b11; tvalid = 2'b11;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_idx); end
    checks++; if (ohv !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid: got %0b expected 0", ohv); end
    checks++; if (otvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", otvalid); end
    checks++; if (hr !== 2'b00) begin errors++; $display("FAIL reset_hdr_ready: got %b expected 00", hr); end
    checks++; if (tready !== 2'b00) begin errors++; $display("FAIL reset_tready: got %b expected 00", tready); end
    hv = 2'b00; tvalid = 2'b00;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_source();
    clear_capture();
    drive_frame(0, 60, 48'hFFFF_FFFF_FFFF, 16'h0806, 0);
    repeat (2) @(negedge clk);
    checks++; if (hdr_grant.size() !== 1) begin errors++; $display("FAIL t1_hdr_count: got %0d expected 1", hdr_grant.size()); end
    if (hdr_grant.size() == 1) begin
      checks++; if (hdr_grant[0] !== 0) begin errors++; $display("FAIL t1_hdr_grant: got %0d expected 0", hdr_grant[0]); end
      checks++; if (hdr_dest[0] !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL t1_dest: got %h expected ffffffffffff", hdr_dest[0]); end
      checks++; if (hdr_type[0] !== 32'h0806) begin errors++; $display("FAIL t1_type: got %h expected 0806", hdr_type[0]); end
    end
    checks++; if (beat_data.size() !== 60) begin errors++; $display("FAIL t1_beats: got %0d expected 60", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 60; i++) begin
      checks++;
      if (beat_data[i] !== i || beat_last[i] !== int'(i == 59) || beat_user[i] !== (i % 2) || beat_grant[i] !== 0) begin
        errors++;
        $display("FAIL t1_beat%0d: got data=%h last=%0d user=%0d grant=%0d expected data=%h last=%0d user=%0d grant=0",
                 i, beat_data[i], beat_last[i], beat_user[i], beat_grant[i], i, int'(i == 59), i % 2);
      end
    end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL t1_busy_during: got %0d idle beats expected 0", busy_bad); end
    checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL t1_grant_hold: got %0d expected 0", grant_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_contention();
    int exp_d[16];
    int exp_g[4];
    do_reset();
    clear_capture();
    for (int f = 0; f < 4; f++) begin
      exp_g[f] = f % 2;
      for (int i = 0; i < 4; i++) exp_d[f*4 + i] = (f % 2) * 'h40 + (f / 2) * 'h10 + i;
    end
    fork
      begin drive_frame(0, 4, 48'h0A0A_0A0A_0A0A, 16'h0800, 'h00); drive_frame(0, 4, 48'h0A0A_0A0A_0A0A, 16'h0800, 'h10); end
      begin drive_frame(1, 4, 48'h0B0B_0B0B_0B0B, 16'h0806, 'h40); drive_frame(1, 4, 48'h0B0B_0B0B_0B0B, 16'h0806, 'h50); end
    join
    repeat (2) @(negedge clk);
    checks++; if (hdr_grant.size() !== 4) begin errors++; $display("FAIL t2_hdr_count: got %0d expected 4", hdr_grant.size()); end
    for (int f = 0; f < hdr_grant.size() && f < 4; f++) begin
      checks++; if (hdr_grant[f] !== exp_g[f]) begin errors++; $display("FAIL t2_order%0d: got port %0d expected port %0d", f, hdr_grant[f], exp_g[f]); end
    end
    checks++; if (beat_data.size() !== 16) begin errors++; $display("FAIL t2_beats: got %0d expected 16", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 16; i++) begin
      checks++;
      if (beat_data[i] !== exp_d[i] || beat_grant[i] !== exp_g[i / 4]) begin
        errors++; $display("FAIL t2_beat%0d: got data=%h grant=%0d expected data=%h grant=%0d", i, beat_data[i], beat_grant[i], exp_d[i], exp_g[i / 4]);
      end
    end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL t2_timeouts: got %0d expected 0", timeouts); end
  endtask

  task automatic test_backpressure();
    int bad;
    clear_capture();
    bp_en = 1'b1;
    tvalid[1] = 1'b1; tdata[1] = 8'hAA; tlast[1] = 1'b1;
    drive_frame(0, 60, 48'h1122_3344_5566, 16'h0800, 0);
    bp_en = 1'b0;
    repeat (4) @(negedge clk);
    tvalid[1] = 1'b0; tlast[1] = 1'b0;
    checks++; if (beat_data.size() !== 60) begin errors++; $display("FAIL t3_beats: got %0d expected 60", beat_data.size()); end
    bad = 0;
    for (int i = 0; i < beat_data.size() && i < 60; i++) if (beat_data[i] !== i || beat_grant[i] !== 0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL t3_sequence: got %0d bad bytes expected 0", bad); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL t3_other_ready: got %0d stray readys expected 0", ready_bad); end
  endtask

  task automatic test_single_beat();
    do_reset();
    clear_capture();
    fork
      drive_frame(0, 1, 48'h0000_0000_0001, 16'h88B5, 'h77);
      drive_frame(1, 1, 48'h0000_0000_0002, 16'h88B6, 'h88);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (hdr_cyc.size() !== 2 || beat_cyc.size() !== 2) begin
      errors++; $display("FAIL t4_counts: got hdr=%0d beats=%0d expected 2 and 2", hdr_cyc.size(), beat_cyc.size());
    end else begin
      checks++; if (beat_data[0] !== 'h77 || beat_last[0] !== 1 || beat_grant[0] !== 0) begin errors++; $display("FAIL t4_first: got data=%h last=%0d grant=%0d expected 77 1 0", beat_data[0], beat_last[0], beat_grant[0]); end
      checks++; if (beat_data[1] !== 'h88 || beat_last[1] !== 1 || beat_grant[1] !== 1) begin errors++; $display("FAIL t4_second: got data=%h last=%0d grant=%0d expected 88 1 1", beat_data[1], beat_last[1], beat_grant[1]); end
      checks++; if (beat_cyc[0] - hdr_cyc[0] !== 1) begin errors++; $display("FAIL t4_hdr_to_beat: got %0d expected 1", beat_cyc[0] - hdr_cyc[0]); end
      checks++; if (hdr_cyc[1] - beat_cyc[0] !== 2) begin errors++; $display("FAIL t4_idle_gap: got %0d expected 2", hdr_cyc[1] - beat_cyc[0]); end
    end
  endtask

  task automatic test_reset_mid_payload();
    int n;
    clear_capture();
    fork
      drive_frame(0, 20, 48'h0C0C_0C0C_0C0C, 16'h0800, 'h00);
      begin
        n = 0;
        while (beat_data.size() < 5 && n < 500) begin @(negedge clk); n++; end
        checks++; if (n >= 500) begin errors++; $display("FAIL t5_wait: got %0d beats expected 5", beat_data.size()); end
        @(negedge clk); #1 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %0b expected 0", busy); end
        checks++; if (otvalid !== 1'b0 || ohv !== 1'b0) begin errors++; $display("FAIL t5_valids: got tvalid=%0b hvalid=%0b expected 0 0", otvalid, ohv); end
        checks++; if (tready !== 2'b00 || hr !== 2'b00) begin errors++; $display("FAIL t5_readys: got tready=%b hready=%b expected 00 00", tready, hr); end
      end
    join
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_capture();
    fork
      drive_frame(1, 3, 48'h0D0D_0D0D_0D0D, 16'h0806, 'h90);
      drive_frame(0, 3, 48'h0E0E_0E0E_0E0E, 16'h0800, 'h80);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (beat_data.size() !== 6) begin
      errors++; $display("FAIL t5_after_beats: got %0d expected 6", beat_data.size());
    end else begin
      checks++;
      if (beat_data[0] !== 'h80 || beat_data[2] !== 'h82 || beat_data[3] !== 'h90 || beat_data[5] !== 'h92 || beat_grant[0] !== 0 || beat_grant[3] !== 1)
        begin errors++; $display("FAIL t5_after_order: got %h,%h,%h,%h grants %0d,%0d expected 80,82,90,92 grants 0,1",
                                  beat_data[0], beat_data[2], beat_data[3], beat_data[5], beat_grant[0], beat_grant[3]); end
    end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL t5_timeouts: got %0d expected 0", timeouts); end
  endtask

`ifdef ETH_TX_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (frame_count !== '0) begin errors++; $display("FAIL t6_reset: got %h expected 0", frame_count); end
    for (int k = 0; k < 3; k++) drive_frame(1, 2, 48'h0F0F_0F0F_0F0F, 16'h0800, k * 4);
    for (int k = 0; k < 2; k++) drive_frame(0, 3, 48'h0F0F_0F0F_0F0F, 16'h0800, k * 4);
    repeat (2) @(negedge clk);
    checks++; if (frame_count[0] !== 32'd2) begin errors++; $display("FAIL t6_port0: got %0d expected 2", frame_count[0]); end
    checks++; if (frame_count[1] !== 32'd3) begin errors++; $display("FAIL t6_port1: got %0d expected 3", frame_count[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_single_beat();
    test_reset_mid_payload();
`ifdef ETH_TX_ARBITER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
